// File: rtl/nr_recip_seq.sv
// nr_recip_seq: fp32 reciprocal controller around an external X*(2-D*X) Newton-Raphson stage.
// Normalises D into [0.5,1), seeds X0 from a LUT, iterates, then rebuilds the exponent.
module nr_recip_seq #(
  parameter int ITERS      = 3,
  parameter int XN_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_recip,
  output logic [2:0]  out_flags,
  output logic        busy,
  output logic [31:0] nr_d,
  output logic [31:0] nr_x,
  input  logic [31:0] nr_xn
);

  localparam int LW = (XN_LATENCY > 1) ? $clog2(XN_LATENCY) : 1;
  localparam logic [2:0]    ROUND_LAST = 3'(ITERS - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(XN_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_ITER,
    S_PACK,
    S_OUT
  } state_e;

  state_e        state_q, state_d;
  logic          sign_q, sign_d;
  logic [7:0]    exp_q, exp_d;
  logic [31:0]   nr_d_q, nr_d_d;
  logic [31:0]   nr_x_q, nr_x_d;
  logic [2:0]    round_q, round_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_recip_q, out_recip_d;
  logic [2:0]    out_flags_q, out_flags_d;
  logic [9:0]    pack_r;

  // X0[i] = 32/(17+2i): reciprocal of the midpoint of each 1/16-wide slice of [0.5,1).
  function automatic logic [31:0] seed_lut(input logic [2:0] idx);
    logic [31:0] x0;
    case (idx)
      3'd0:    x0 = 32'h3FF0F0F1;
      3'd1:    x0 = 32'h3FD79436;
      3'd2:    x0 = 32'h3FC30C31;
      3'd3:    x0 = 32'h3FB21643;
      3'd4:    x0 = 32'h3FA3D70A;
      3'd5:    x0 = 32'h3F97B426;
      3'd6:    x0 = 32'h3F8D3DCB;
      default: x0 = 32'h3F842108;
    endcase
    return x0;
  endfunction

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    nr_d_d      = nr_d_q;
    nr_x_d      = nr_x_q;
    round_d     = round_q;
    lat_d       = lat_q;
    out_valid_d = out_valid_q;
    out_recip_d = out_recip_q;
    out_flags_d = out_flags_q;
    pack_r      = {2'b00, nr_x_q[30:23]} + 10'd126 - {2'b00, exp_q};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = in_d[31];
          exp_d  = in_d[30:23];
          if (in_d[30:23] == 8'd0) begin
            out_recip_d = {in_d[31], 8'hFF, 23'd0};
            out_flags_d = 3'b100;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else if (in_d[30:23] == 8'hFF) begin
            if (in_d[22:0] != 23'd0) begin
              out_recip_d = 32'h7FC00000;
              out_flags_d = 3'b010;
            end else begin
              out_recip_d = {in_d[31], 31'd0};
              out_flags_d = 3'b000;
            end
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            nr_d_d  = {1'b0, 8'd126, in_d[22:0]};
            state_d = S_SEED;
          end
        end
      end
      S_SEED: begin
        nr_x_d  = seed_lut(nr_d_q[22:20]);
        round_d = 3'd0;
        lat_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (lat_q == LAT_LAST) begin
          nr_x_d = nr_xn;
          lat_d  = '0;
          if (round_q == ROUND_LAST) begin
            round_d = 3'd0;
            state_d = S_PACK;
          end else begin
            round_d = round_q + 3'd1;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_PACK: begin
        // X lies in (1,2], so its exponent minus the original one restores the scale of 1/D.
        if (pack_r[9] || pack_r == 10'd0) begin
          out_recip_d = {sign_q, 31'd0};
          out_flags_d = 3'b001;
        end else begin
          out_recip_d = {sign_q, pack_r[7:0], nr_x_q[22:0]};
          out_flags_d = 3'b000;
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= 8'd0;
      nr_d_q      <= 32'd0;
      nr_x_q      <= 32'd0;
      round_q     <= 3'd0;
      lat_q       <= '0;
      out_valid_q <= 1'b0;
      out_recip_q <= 32'd0;
      out_flags_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      nr_d_q      <= nr_d_d;
      nr_x_q      <= nr_x_d;
      round_q     <= round_d;
      lat_q       <= lat_d;
      out_valid_q <= out_valid_d;
      out_recip_q <= out_recip_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_recip = out_recip_q;
  assign out_flags = out_flags_q;
  assign nr_d      = nr_d_q;
  assign nr_x      = nr_x_q;

endmodule

// File: doc/nr_recip_seq.md
Name: nr_recip_seq

Overview:
- Sequential controller that computes the IEEE-754 single-precision reciprocal 1/D by Newton-Raphson iteration.
- Sits directly upstream of the combinational X = X*(2-D*X) iteration stage:
  - normalises D into [0.5,1) and seeds X0 from a LUT;
  - drives the stage's D/X inputs and re-registers its Xn output for ITERS rounds;
  - re-applies the exponent and handles the special operands.
- Valid/ready on both sides; one operand in flight at a time.

Parameters:
ITERS, 3, number of Newton-Raphson rounds (1..7).
XN_LATENCY, 1, cycles nr_x/nr_d are held before nr_xn is captured (1 = combinational stage; >1 for a pipelined stage).

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand valid.
in_ready  output  1  high only in IDLE.
in_d  input  32  divisor D, fp32.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts when high with out_valid.
out_recip  output  32  1/D, fp32.
out_flags  output  3  [2] div_by_zero, [1] invalid (NaN in), [0] underflow (flushed to zero).
busy  output  1  high in any state except IDLE.
nr_d  output  32  D' to the iteration stage.
nr_x  output  32  current X to the iteration stage.
nr_xn  input  32  Xn returned by the iteration stage.

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, out_valid=0, out_recip=0, out_flags=0, nr_d=0, nr_x=0, iteration/latency counters=0. Any in-flight operand is discarded; no output is produced for it.
- States: IDLE, SEED, ITER, PACK, OUT.
- IDLE: in_ready=1. in_valid=1 at an edge captures in_d as {s,e,m}.
- Special operands go straight to OUT with flags:
  - e==0 (zero or denormal, denormals flushed): out_recip={s,0xFF,0} (signed inf), flags=100.
  - e==255, m!=0: out_recip=0x7FC00000, flags=010.
  - e==255, m==0: out_recip={s,31'b0}, flags=000.
- Otherwise the next state is SEED and D'={0,8'd126,m} is registered on nr_d.
- SEED (1 cycle): nr_x <= X0[m[22:20]]. X0[i] is 32/(17+2i) rounded to nearest fp32, i.e. 1/midpoint of [0.5+i/16, 0.5+(i+1)/16). Go to ITER.
- ITER: nr_d and nr_x held stable. On the XN_LATENCY-th cycle of each round, nr_x <= nr_xn and the round counter increments. After ITERS rounds go to PACK.
- PACK (1 cycle): with xe = exponent field of nr_x and xm its mantissa:
  - compute r = xe - e + 126, signed 10-bit;
  - r<=0: out_recip={s,31'b0}, flags=001;
  - else out_recip={s, r[7:0], xm}, flags=000.
  - r cannot exceed 254.
- OUT: out_valid=1; out_recip/out_flags stable. out_valid & out_ready at an edge -> IDLE, out_valid=0.
- No new operand is accepted in the OUT cycle itself: in_ready is low, so back-to-back operation costs one IDLE cycle.
- Latency from the accept edge to out_valid=1:
  - normal path: 2 + ITERS*XN_LATENCY cycles (5 at defaults);
  - special path: 1 cycle.
- nr_d/nr_x hold their last values outside ITER; the downstream stage is don't-care then.
- in_valid while busy is ignored (in_ready=0). out_ready while not in OUT is ignored.

Test Plan:
- Bench uses a behavioural X*(2-D*X) model on nr_xn; defaults ITERS=3, XN_LATENCY=1.
- in_d=0x40800000 (4.0) -> nr_d=0x3F000000, nr_x=X0[0]≈0x3FF0F0F1 after SEED; out_recip=0x3E800000 (±2 ulp), flags=000, out_valid 5 cycles after accept.
- in_d=0x40400000 (3.0) -> seed index 4 (X0=1.28); out_recip=0x3EAAAAAB ±2 ulp. Same for 0xC0000000 (-2.0) -> 0xBF000000 ±2 ulp.
- in_d=0x00000000 -> 0x7F800000, flags=100, out_valid 1 cycle after accept. Also:
  - 0x80000000 -> 0xFF800000;
  - 0x00000001 (denormal) -> 0x7F800000, flags=100;
  - 0x7FA00000 -> 0x7FC00000, flags=010;
  - 0xFF800000 -> 0x80000000, flags=000.
- in_d=0x7F000000 (2^127) -> out_recip=0x00000000, flags=001.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid/out_recip stable, in_ready=0 throughout. Raise out_ready -> IDLE next cycle, then accept the next operand.
- Assert rst for one cycle during ITER (round 2) -> next cycle IDLE, in_ready=1, out_valid=0, no stale result. A following 0x3F800000 (1.0) -> 0x3F800000 ±2 ulp.
- Sweep ITERS=1 and XN_LATENCY=3 with in_d=0x40400000:
  - out_valid exactly 2+ITERS*XN_LATENCY cycles after accept;
  - nr_x changes only on round boundaries.
